// File: rtl/block_lock_manager_if.sv
// Handshake bundle between the readout comm FSM / digitizer writer (master)
// and the block lock manager (slave).
interface block_lock_manager_if #(
  parameter int BLOCK_WIDTH = 9
);
  logic [BLOCK_WIDTH-1:0] lock_address_i;
  logic                   lock_i;
  logic                   unlock_i;
  logic                   lock_strobe_i;
  logic                   lock_ack_o;
  logic [BLOCK_WIDTH-1:0] free_address_i;
  logic                   free_strobe_i;
  logic                   free_ack_o;
  logic                   write_done_i;
  logic [BLOCK_WIDTH-1:0] write_block_o;
  logic                   write_ready_o;
  logic                   full_o;
  logic                   overrun_o;
  logic                   error_o;

  modport master (
    output lock_address_i, lock_i, unlock_i, lock_strobe_i,
    output free_address_i, free_strobe_i, write_done_i,
    input  lock_ack_o, free_ack_o, write_block_o, write_ready_o,
    input  full_o, overrun_o, error_o
  );

  modport slave (
    input  lock_address_i, lock_i, unlock_i, lock_strobe_i,
    input  free_address_i, free_strobe_i, write_done_i,
    output lock_ack_o, free_ack_o, write_block_o, write_ready_o,
    output full_o, overrun_o, error_o
  );
endinterface

// File: rtl/block_lock_manager.sv
// Block lock/in-use bitmap owner: lock strobes acked in 1 cycle, frees acked 2 cycles after strobe,
// writer gets the next free+unlocked block one candidate per cycle. BLOCK_LOCK_STATS_EN adds locked_count_o.
module block_lock_manager #(
  parameter int BLOCK_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  block_lock_manager_if.slave  bus
`ifdef BLOCK_LOCK_STATS_EN
  ,
  output logic [BLOCK_WIDTH:0] locked_count_o
`endif
);
  localparam int DEPTH = 1 << BLOCK_WIDTH;

  typedef enum logic [1:0] {F_IDLE, F_CHECK, F_ACK} free_state_t;
  typedef enum logic {A_READY, A_SEARCH} alloc_state_t;

  logic [DEPTH-1:0]       lock_map;
  logic [DEPTH-1:0]       use_map;

  logic                   pend_vld;
  logic                   pend_lock;
  logic                   pend_unlock;
  logic [BLOCK_WIDTH-1:0] pend_addr;

  free_state_t            free_state;
  logic [BLOCK_WIDTH-1:0] free_addr;
  logic                   free_ack;
  logic                   free_err;

  alloc_state_t           alloc_state;
  logic [BLOCK_WIDTH-1:0] cand;
  logic [BLOCK_WIDTH-1:0] cand_next;
  logic [BLOCK_WIDTH-1:0] start_blk;
  logic [BLOCK_WIDTH-1:0] write_block;
  logic                   write_ready;
  logic                   full;
  logic                   overrun;

  assign cand_next = cand + 1'b1;

  assign bus.lock_ack_o    = pend_vld;
  assign bus.free_ack_o    = free_ack;
  assign bus.error_o       = free_err;
  assign bus.write_block_o = write_block;
  assign bus.write_ready_o = write_ready;
  assign bus.full_o        = full;
  assign bus.overrun_o     = overrun;

  // The request is registered at the strobe edge and applied one edge later, alongside its ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_vld    <= 1'b0;
      pend_lock   <= 1'b0;
      pend_unlock <= 1'b0;
      pend_addr   <= '0;
      lock_map    <= '0;
    end else begin
      pend_vld    <= bus.lock_strobe_i;
      pend_lock   <= bus.lock_i;
      pend_unlock <= bus.unlock_i;
      pend_addr   <= bus.lock_address_i;
      if (pend_vld) begin
        if (pend_lock) begin
          lock_map[pend_addr] <= 1'b1;
        end else if (pend_unlock) begin
          lock_map[pend_addr] <= 1'b0;
        end
      end
    end
  end

`ifdef BLOCK_LOCK_STATS_EN
  logic cur_locked;

  // A request still in flight to the same block decides its lock state before the bitmap does.
  always_comb begin
    cur_locked = lock_map[bus.lock_address_i];
    if (pend_vld && (pend_addr == bus.lock_address_i) && (pend_lock || pend_unlock)) begin
      cur_locked = pend_lock;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_count_o <= '0;
    end else if (bus.lock_strobe_i) begin
      if (bus.lock_i && !cur_locked) begin
        locked_count_o <= locked_count_o + 1'b1;
      end else if (!bus.lock_i && bus.unlock_i && cur_locked) begin
        locked_count_o <= locked_count_o - 1'b1;
      end
    end
  end
`endif

  // Free FSM and write allocator share use_map; the allocator's set is written last so it wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      use_map     <= '0;
      free_state  <= F_IDLE;
      free_addr   <= '0;
      free_ack    <= 1'b0;
      free_err    <= 1'b0;
      alloc_state <= A_READY;
      cand        <= '0;
      start_blk   <= '0;
      write_block <= '0;
      write_ready <= 1'b1;
      full        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;

      case (free_state)
        F_IDLE: begin
          if (bus.free_strobe_i) begin
            free_addr  <= bus.free_address_i;
            free_state <= F_CHECK;
          end
        end
        F_CHECK: begin
          free_err   <= lock_map[free_addr] | ~use_map[free_addr];
          free_ack   <= 1'b1;
          free_state <= F_ACK;
        end
        F_ACK: begin
          free_ack            <= 1'b0;
          free_err            <= 1'b0;
          use_map[free_addr]  <= 1'b0;
          free_state          <= F_IDLE;
        end
        default: free_state <= F_IDLE;
      endcase

      case (alloc_state)
        A_READY: begin
          if (bus.write_done_i) begin
            use_map[write_block] <= 1'b1;
            write_ready          <= 1'b0;
            cand                 <= write_block + 1'b1;
            start_blk            <= write_block;
            alloc_state          <= A_SEARCH;
          end
        end
        A_SEARCH: begin
          if (bus.write_done_i) begin
            overrun <= 1'b1;
          end
          if (!use_map[cand] && !lock_map[cand]) begin
            write_block <= cand;
            write_ready <= 1'b1;
            full        <= 1'b0;
            alloc_state <= A_READY;
          end else begin
            cand <= cand_next;
            if (cand_next == start_blk) begin
              full <= 1'b1;
            end
          end
        end
        default: alloc_state <= A_READY;
      endcase
    end
  end
endmodule

// File: tb/tb_block_lock_manager.sv
// Scenario bench for block_lock_manager: a reference bitmap model predicts acks, errors and
// allocated blocks into queues that are popped when the DUT responds.
module tb_block_lock_manager;
  localparam int BW    = 9;
  localparam int DEPTH = 1 << BW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  block_lock_manager_if #(.BLOCK_WIDTH(BW)) bus ();
`ifdef BLOCK_LOCK_STATS_EN
  logic [BW:0] locked_count;
`endif

  block_lock_manager #(.BLOCK_WIDTH(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef BLOCK_LOCK_STATS_EN
    ,
    .locked_count_o (locked_count)
`endif
  );

  bit m_lock [DEPTH];
  bit m_use  [DEPTH];
  int m_wb;
  int m_cnt;

  int exp_lat_q [$];
  int exp_blk_q [$];
  bit exp_err_q [$];

  int checks = 0;
  int errors = 0;

  function automatic int model_next(input int from, output int rej);
    int idx;
    rej = 0;
    for (int i = 1; i <= DEPTH; i++) begin
      idx = (from + i) % DEPTH;
      if (!m_use[idx] && !m_lock[idx]) return idx;
      rej++;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_lock[i] = 1'b0;
      m_use[i]  = 1'b0;
    end
    m_wb  = 0;
    m_cnt = 0;
  endtask

  task automatic lock_op(input int addr, input bit l, input bit u);
    int lat;
    int e_lat;
    bit seen;
    bus.lock_address_i = BW'(addr);
    bus.lock_i         = l;
    bus.unlock_i       = u;
    bus.lock_strobe_i  = 1'b1;
    exp_lat_q.push_back(1);
    if (l && !m_lock[addr]) m_cnt++;
    else if (!l && u && m_lock[addr]) m_cnt--;
    if (l) m_lock[addr] = 1'b1;
    else if (u) m_lock[addr] = 1'b0;
    @(posedge clk); #1;
    bus.lock_strobe_i = 1'b0;
    bus.lock_i        = 1'b0;
    bus.unlock_i      = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (bus.lock_ack_o) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
    end
    e_lat = exp_lat_q.pop_front();
    checks++;
    if (!seen || lat != e_lat) begin
      errors++;
      $display("FAIL lock_ack_latency addr=%0d: got seen=%0b lat=%0d, expected lat=%0d", addr, seen, lat, e_lat);
    end
`ifdef BLOCK_LOCK_STATS_EN
    checks++;
    if (locked_count !== (BW+1)'(m_cnt)) begin
      errors++;
      $display("FAIL locked_count: got %0d expected %0d", locked_count, m_cnt);
    end
`endif
    @(negedge clk);
    checks++;
    if (bus.lock_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL lock_ack_single: got %0b expected 0", bus.lock_ack_o);
    end
  endtask

  // Returns none_left=1 when the model predicts the search cannot succeed.
  task automatic done_op(output bit none_left);
    int rej;
    int nxt;
    int k;
    int e_blk;
    int e_lat;
    bit got;
    m_use[m_wb] = 1'b1;
    nxt = model_next(m_wb, rej);
    none_left = (nxt < 0);
    bus.write_done_i = 1'b1;
    @(posedge clk); #1;
    bus.write_done_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.write_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL alloc_ready_low: got %0b expected 0", bus.write_ready_o);
    end
    if (!none_left) begin
      exp_blk_q.push_back(nxt);
      exp_lat_q.push_back(rej + 1);
      got = 1'b0;
      k   = 0;
      for (int i = 1; i <= DEPTH + 2; i++) begin
        @(negedge clk);
        if (bus.write_ready_o) begin
          got = 1'b1;
          k   = i;
          break;
        end
      end
      e_blk = exp_blk_q.pop_front();
      e_lat = exp_lat_q.pop_front();
      checks++;
      if (!got || int'(bus.write_block_o) != e_blk || k != e_lat) begin
        errors++;
        $display("FAIL alloc_block: got ready=%0b block=%0d cycles=%0d, expected block=%0d cycles=%0d",
                 got, bus.write_block_o, k, e_blk, e_lat);
      end
      m_wb = nxt;
    end
  endtask

  task automatic free_op(input int addr);
    bit seen;
    int lat;
    int e_lat;
    bit e_err;
    bit got_err;
    exp_err_q.push_back(m_lock[addr] || !m_use[addr]);
    exp_lat_q.push_back(2);
    bus.free_address_i = BW'(addr);
    bus.free_strobe_i  = 1'b1;
    @(posedge clk);
    seen    = 1'b0;
    lat     = 0;
    got_err = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (bus.free_ack_o) begin
        seen    = 1'b1;
        lat     = i;
        got_err = bus.error_o;
        break;
      end
    end
    @(posedge clk); #1;
    bus.free_strobe_i = 1'b0;
    m_use[addr] = 1'b0;
    e_err = exp_err_q.pop_front();
    e_lat = exp_lat_q.pop_front();
    checks++;
    if (!seen || lat != e_lat || got_err !== e_err) begin
      errors++;
      $display("FAIL free_ack addr=%0d: got seen=%0b lat=%0d error=%0b, expected lat=%0d error=%0b",
               addr, seen, lat, got_err, e_lat, e_err);
    end
    @(negedge clk);
    checks++;
    if (bus.free_ack_o !== 1'b0 || bus.error_o !== 1'b0) begin
      errors++;
      $display("FAIL free_ack_single: got ack=%0b error=%0b expected 0/0", bus.free_ack_o, bus.error_o);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.write_block_o !== '0 || bus.write_ready_o !== 1'b1 || bus.full_o !== 1'b0 ||
        bus.lock_ack_o !== 1'b0 || bus.free_ack_o !== 1'b0 || bus.overrun_o !== 1'b0 ||
        bus.error_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got block=%0d ready=%0b full=%0b lack=%0b fack=%0b ovr=%0b err=%0b, expected 0 1 0 0 0 0 0",
               bus.write_block_o, bus.write_ready_o, bus.full_o, bus.lock_ack_o,
               bus.free_ack_o, bus.overrun_o, bus.error_o);
    end
  endtask

  task automatic test_alloc();
    bit nl;
    done_op(nl);
    lock_op(2, 1'b1, 1'b0);
    lock_op(3, 1'b1, 1'b0);
    done_op(nl);
  endtask

  task automatic test_lock_unlock();
    bit nl;
    lock_op(5, 1'b1, 1'b0);
    lock_op(5, 1'b0, 1'b1);
    done_op(nl);
    done_op(nl);
    free_op(5);
  endtask

  task automatic test_lock_priority();
    bit nl;
    lock_op(7, 1'b1, 1'b1);
    done_op(nl);
    lock_op(7, 1'b0, 1'b1);
    lock_op(7, 1'b0, 1'b0);
  endtask

  task automatic test_free_errors();
    bit nl;
    while (m_wb <= 9) done_op(nl);
    lock_op(9, 1'b1, 1'b0);
    free_op(9);
    free_op(200);
    lock_op(9, 1'b0, 1'b1);
    lock_op(2, 1'b0, 1'b1);
    lock_op(3, 1'b0, 1'b1);
  endtask

  task automatic test_fill();
    bit nl;
    bit got;
    nl = 1'b0;
    for (int n = 0; n < DEPTH + 8 && !nl; n++) done_op(nl);
    got = 1'b0;
    for (int i = 0; i < DEPTH + 8; i++) begin
      @(negedge clk);
      if (bus.full_o) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got || bus.write_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_flag: got full=%0b ready=%0b expected 1/0", got, bus.write_ready_o);
    end
    @(posedge clk); #1;
    bus.write_done_i = 1'b1;
    @(posedge clk); #1;
    bus.write_done_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.overrun_o !== 1'b1) begin
      errors++;
      $display("FAIL overrun_pulse: got %0b expected 1", bus.overrun_o);
    end
    @(negedge clk);
    checks++;
    if (bus.overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL overrun_single: got %0b expected 0", bus.overrun_o);
    end
    free_op(300);
    exp_blk_q.push_back(300);
    got = bus.write_ready_o;
    for (int i = 0; i < DEPTH && !got; i++) begin
      @(negedge clk);
      got = bus.write_ready_o;
    end
    checks++;
    if (!got || int'(bus.write_block_o) != exp_blk_q.pop_front() || bus.full_o !== 1'b0) begin
      errors++;
      $display("FAIL refill_after_full: got ready=%0b block=%0d full=%0b expected 1/300/0",
               got, bus.write_block_o, bus.full_o);
    end
    m_wb = 300;
  endtask

  task automatic test_reset_mid_free();
    bit nl;
    int acks;
    lock_op(1, 1'b1, 1'b0);
    @(posedge clk); #1;
    bus.free_address_i = BW'(300);
    bus.free_strobe_i  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.write_block_o !== '0 || bus.write_ready_o !== 1'b1 || bus.full_o !== 1'b0 ||
        bus.free_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got block=%0d ready=%0b full=%0b fack=%0b expected 0 1 0 0",
               bus.write_block_o, bus.write_ready_o, bus.full_o, bus.free_ack_o);
    end
    bus.free_strobe_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.free_ack_o) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL reset_abort_free: got %0d acks expected 0", acks);
    end
`ifdef BLOCK_LOCK_STATS_EN
    checks++;
    if (locked_count !== '0) begin
      errors++;
      $display("FAIL reset_locked_count: got %0d expected 0", locked_count);
    end
`endif
    @(posedge clk); #1;
    done_op(nl);
  endtask

  initial begin
    reset              = 1'b1;
    bus.lock_address_i = '0;
    bus.lock_i         = 1'b0;
    bus.unlock_i       = 1'b0;
    bus.lock_strobe_i  = 1'b0;
    bus.free_address_i = '0;
    bus.free_strobe_i  = 1'b0;
    bus.write_done_i   = 1'b0;
    model_clear();
    test_reset();
    @(posedge clk); #1;
    test_alloc();
    test_lock_unlock();
    test_lock_priority();
    test_free_errors();
    test_fill();
    test_reset_mid_free();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
